syn_wm8731_i2s_drvr: RTL and testbench
======================================

Name: syn_wm8731_i2s_drvr

Overview:
- Audio serial driver for the WM8731 codec, with the codec in slave mode. It sits between the audio sample datapath and the codec's digital audio pins.
- Generates bclk and the ADC/DAC LRC clocks in I2S format. Serialises stereo DAC samples and deserialises stereo ADC samples.
- Drives the codec-side signals of the wmdrvr group: bclk, adc_dat, adc_lrc, dac_dat, dac_lrc.

Parameters:
- DATA_W, 16: sample width in bits per channel.
- SLOT_BCLKS, 32: bclk periods per channel slot. Must be ≥ DATA_W+1.
- BCLK_DIV, 4: bclk half-period in clk_ir cycles. Must be ≥ 2.

Ports:
- clk_ir  in  1  system clock
- rst_il  in  1  asynchronous active-low reset
- drvr_en_i  in  1  run enable
- dac_ldata_i  in  DATA_W  left DAC sample
- dac_rdata_i  in  DATA_W  right DAC sample
- dac_valid_i  in  1  DAC sample pair valid
- dac_ready_o  out  1  holding buffer empty; a pair is accepted when valid&ready
- dac_underflow_o  out  1  one-cycle pulse: frame started with the buffer empty
- adc_ldata_o  out  DATA_W  captured left ADC sample
- adc_rdata_o  out  DATA_W  captured right ADC sample
- adc_valid_o  out  1  one-cycle pulse: new ADC pair available
- bclk_o  out  1  codec bit clock
- adc_lrc_o  out  1  ADC LR clock
- dac_lrc_o  out  1  DAC LR clock, identical to adc_lrc_o
- dac_dat_o  out  1  serial DAC data
- adc_dat_i  in  1  serial ADC data

Behaviour:
- Clock/reset: one clock, clk_ir. Reset rst_il is asynchronous, active-low.
- Reset values:
  - bclk_o, adc_lrc_o, dac_lrc_o, dac_dat_o = 0.
  - adc_ldata_o, adc_rdata_o = 0.
  - adc_valid_o, dac_underflow_o = 0.
  - dac_ready_o = 1 (buffer empty).
  - FSM = IDLE. All counters = 0. Shift registers = 0.
- FSM states:
  - IDLE → RUN when drvr_en_i=1.
  - RUN → DRAIN when drvr_en_i=0.
  - DRAIN → RUN if drvr_en_i returns to 1 before the frame ends. Otherwise DRAIN → IDLE at frame end (last falling edge of bclk_cnt = 2*SLOT_BCLKS-1).
  - In IDLE: bclk_o, both LRC outputs and dac_dat_o are held at 0, and the counters are held at 0.
- Clock divider:
  - div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN. bclk_o toggles when div_cnt wraps.
  - bclk period = 2*BCLK_DIV clk_ir cycles.
  - The first toggle after leaving IDLE is rising, BCLK_DIV cycles after entry.
- Frame counter:
  - bclk_cnt (0..2*SLOT_BCLKS-1) advances on every bclk falling edge and wraps to 0.
  - The frame starts at bclk_cnt=0.
  - LRC outputs = (bclk_cnt ≥ SLOT_BCLKS). Low means left channel.
- DAC path, I2S one-bit delay:
  - Let p = bclk_cnt mod SLOT_BCLKS. On each falling edge, dac_dat_o = sample bit DATA_W-p for 1≤p≤DATA_W, else 0.
  - Left sample in the low-LRC half, right sample in the high-LRC half. MSB first.
- DAC buffer:
  - Single-entry holding register. Accept on dac_valid_i & dac_ready_o; dac_ready_o drops the next cycle.
  - At each frame start (falling edge into bclk_cnt=0), the buffer moves to the L/R shift registers and dac_ready_o rises next cycle.
  - If the buffer is empty at frame start: zeros are transmitted and dac_underflow_o pulses for 1 cycle.
  - A write cannot coincide with a transfer, because writes need ready=1 and so the buffer is empty.
  - The first frame after IDLE loads from the buffer the same way.
- ADC path:
  - On each rising bclk edge with 1≤p≤DATA_W, adc_dat_i is shifted into the current channel's register, MSB first.
  - After the right-channel LSB is sampled (p=DATA_W, upper half), adc_ldata_o/adc_rdata_o update together. adc_valid_o pulses exactly 1 cycle, in the cycle after the sampling edge.
  - Outputs hold their value until the next update.
  - A frame truncated by IDLE produces no adc_valid_o.
- Reset mid-operation: immediate return to reset values. A held DAC sample is discarded.
- Arithmetic: all counters wrap modulo their range. No saturation.

Test Plan:
- Timing, BCLK_DIV=4, SLOT_BCLKS=32: enable → bclk period 8 clk cycles, LRC period 512 cycles, 50% duty. LRC edges coincide with bclk falling edges.
- Loopback (adc_dat_i=dac_dat_o): push L=16'hA55A, R=16'h1234 → adc_valid_o pulses once with adc_ldata_o=16'hA55A, adc_rdata_o=16'h1234. dac_dat_o carries the left MSB one bclk after the LRC falling edge.
- Buffer handshake: hold dac_valid_i=1 continuously → exactly one pair accepted per frame. dac_ready_o low from acceptance until the next frame start.
- Underflow: enable with no valid → dac_underflow_o pulses once per frame, dac_dat_o stays 0, and adc_valid_o still pulses every frame.
- Enable drain: drop drvr_en_i at bclk_cnt=10 → the frame completes to bclk_cnt=63, then bclk_o/LRC return to 0 (IDLE). Re-enable during DRAIN → no gap in bclk.
- Async reset: assert rst_il at mid-frame, off a clock edge → all outputs go to reset values immediately and dac_ready_o=1. After release the next frame starts at bclk_cnt=0.

Source files
------------

// File: rtl/syn_wm8731_i2s_drvr.sv
// WM8731 I2S serial driver (codec in slave mode).
// Generates bclk and the shared ADC/DAC LR clock, serialises stereo DAC
// samples and deserialises stereo ADC samples in I2S format (one-bit delay).
// Ports:
//   clk_ir, rst_il             system clock, async active-low reset
//   drvr_en_i                  run enable (frames always complete before idling)
//   dac_[lr]data_i/valid_i     DAC sample pair in, single-entry holding buffer
//   dac_ready_o                holding buffer empty
//   dac_underflow_o            1-cycle pulse: frame started with empty buffer
//   adc_[lr]data_o/valid_o     captured ADC pair, valid pulses for one cycle
//   bclk_o, adc_lrc_o, dac_lrc_o, dac_dat_o, adc_dat_i   codec pins
module syn_wm8731_i2s_drvr #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SLOT_BCLKS = 32,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              drvr_en_i,
  input  logic [DATA_W-1:0] dac_ldata_i,
  input  logic [DATA_W-1:0] dac_rdata_i,
  input  logic              dac_valid_i,
  output logic              dac_ready_o,
  output logic              dac_underflow_o,
  output logic [DATA_W-1:0] adc_ldata_o,
  output logic [DATA_W-1:0] adc_rdata_o,
  output logic              adc_valid_o,
  output logic              bclk_o,
  output logic              adc_lrc_o,
  output logic              dac_lrc_o,
  output logic              dac_dat_o,
  input  logic              adc_dat_i
);

  localparam int unsigned FRAME_BCLKS = 2 * SLOT_BCLKS;
  localparam int unsigned CNT_W       = $clog2(FRAME_BCLKS);
  localparam int unsigned DIV_W       = $clog2(BCLK_DIV);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrc_q, lrc_d;
  logic                dat_q, dat_d;
  logic [DATA_W-1:0]   buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                ready_q, ready_d;
  logic                under_q, under_d;
  logic [DATA_W-1:0]   tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [DATA_W-1:0]   rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic [DATA_W-1:0]   adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic                adc_valid_q, adc_valid_d;
  logic                load_c;
  logic                hi_c;
  logic [CNT_W-1:0]    pos_c;

  // Position of a frame count within its channel slot.
  function automatic logic [CNT_W-1:0] slot_pos(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(SLOT_BCLKS)) ? c - CNT_W'(SLOT_BCLKS) : c;
  endfunction

  // Slot positions 1..DATA_W carry sample bits (position 0 is the I2S delay bit).
  function automatic logic in_data(input logic [CNT_W-1:0] p);
    return (p >= CNT_W'(1)) && (p <= CNT_W'(DATA_W));
  endfunction

  // Next-state: FSM, bclk divider, frame counter, shift paths, DAC buffer.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bclk_d      = bclk_q;
    lrc_d       = lrc_q;
    dat_d       = dat_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    ready_d     = ready_q;
    under_d     = 1'b0;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    adc_l_d     = adc_l_q;
    adc_r_d     = adc_r_q;
    adc_valid_d = 1'b0;
    load_c      = 1'b0;
    hi_c        = 1'b0;
    pos_c       = '0;

    if (dac_valid_i && ready_q) begin
      buf_l_d = dac_ldata_i;
      buf_r_d = dac_rdata_i;
      ready_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        cnt_d  = '0;
        bclk_d = 1'b0;
        lrc_d  = 1'b0;
        dat_d  = 1'b0;
        if (drvr_en_i) begin
          state_d = ST_RUN;
          load_c  = 1'b1;
        end
      end
      default: begin
        state_d = drvr_en_i ? ST_RUN : ST_DRAIN;
        if (div_q == DIV_W'(BCLK_DIV - 1)) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            // Falling edge: advance frame, update LRC and DAC bit.
            if (cnt_q == CNT_W'(FRAME_BCLKS - 1)) begin
              cnt_d = '0;
              if (state_q == ST_DRAIN && !drvr_en_i) state_d = ST_IDLE;
              else                                   load_c  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            hi_c  = cnt_d >= CNT_W'(SLOT_BCLKS);
            pos_c = slot_pos(cnt_d);
            lrc_d = hi_c;
            dat_d = 1'b0;
            if (in_data(pos_c)) begin
              if (hi_c) begin
                dat_d  = tx_r_q[DATA_W-1];
                tx_r_d = tx_r_q << 1;
              end else begin
                dat_d  = tx_l_q[DATA_W-1];
                tx_l_d = tx_l_q << 1;
              end
            end
          end else begin
            // Rising edge: sample ADC bit into the current channel.
            hi_c  = cnt_q >= CNT_W'(SLOT_BCLKS);
            pos_c = slot_pos(cnt_q);
            if (in_data(pos_c)) begin
              if (hi_c) begin
                rx_r_d = DATA_W'({rx_r_q, adc_dat_i});
                if (pos_c == CNT_W'(DATA_W)) begin
                  adc_l_d     = rx_l_q;
                  adc_r_d     = rx_r_d;
                  adc_valid_d = 1'b1;
                end
              end else begin
                rx_l_d = DATA_W'({rx_l_q, adc_dat_i});
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    endcase

    // Frame start: move buffer into the shift registers, or send silence.
    // An accept in the same cycle is only possible when the buffer was empty.
    if (load_c) begin
      if (ready_q) begin
        tx_l_d  = '0;
        tx_r_d  = '0;
        under_d = 1'b1;
      end else begin
        tx_l_d  = buf_l_q;
        tx_r_d  = buf_r_q;
        ready_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bclk_q      <= 1'b0;
      lrc_q       <= 1'b0;
      dat_q       <= 1'b0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      ready_q     <= 1'b1;
      under_q     <= 1'b0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      adc_l_q     <= '0;
      adc_r_q     <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bclk_q      <= bclk_d;
      lrc_q       <= lrc_d;
      dat_q       <= dat_d;
      buf_l_q     <= buf_l_d;
      buf_r_q     <= buf_r_d;
      ready_q     <= ready_d;
      under_q     <= under_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      adc_l_q     <= adc_l_d;
      adc_r_q     <= adc_r_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  assign bclk_o          = bclk_q;
  assign adc_lrc_o       = lrc_q;
  assign dac_lrc_o       = lrc_q;
  assign dac_dat_o       = dat_q;
  assign dac_ready_o     = ready_q;
  assign dac_underflow_o = under_q;
  assign adc_ldata_o     = adc_l_q;
  assign adc_rdata_o     = adc_r_q;
  assign adc_valid_o     = adc_valid_q;

endmodule

// File: tb/tb_syn_wm8731_i2s_drvr.sv
// Testbench for syn_wm8731_i2s_drvr: ADC looped back from DAC, cycle model of
// bclk/LRC/buffer timing, scoreboard of expected ADC pairs, drain and reset.
module tb_syn_wm8731_i2s_drvr;
  localparam int unsigned DW = 16;
  localparam int unsigned LAST_G = 5135;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk_ir = 1'b0;
  logic          rst_il = 1'b0;
  logic          drvr_en = 1'b0;
  logic [DW-1:0] dac_l = '0;
  logic [DW-1:0] dac_r = '0;
  logic          dac_valid = 1'b0;
  logic          dac_ready, dac_under;
  logic [DW-1:0] adc_l, adc_r;
  logic          adc_valid, bclk, adc_lrc, dac_lrc, dac_dat, adc_dat;

  always #5 clk_ir = ~clk_ir;

  syn_wm8731_i2s_drvr #(.DATA_W(DW), .SLOT_BCLKS(32), .BCLK_DIV(4)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il), .drvr_en_i(drvr_en),
    .dac_ldata_i(dac_l), .dac_rdata_i(dac_r), .dac_valid_i(dac_valid),
    .dac_ready_o(dac_ready), .dac_underflow_o(dac_under),
    .adc_ldata_o(adc_l), .adc_rdata_o(adc_r), .adc_valid_o(adc_valid),
    .bclk_o(bclk), .adc_lrc_o(adc_lrc), .dac_lrc_o(dac_lrc),
    .dac_dat_o(dac_dat), .adc_dat_i(adc_dat)
  );

  assign adc_dat = dac_dat;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  pair_t       sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_bclk"},  32'(bclk), 0);
    check({pfx, "_alrc"},  32'(adc_lrc), 0);
    check({pfx, "_dlrc"},  32'(dac_lrc), 0);
    check({pfx, "_dat"},   32'(dac_dat), 0);
    check({pfx, "_ready"}, 32'(dac_ready), 1);
    check({pfx, "_under"}, 32'(dac_under), 0);
    check({pfx, "_valid"}, 32'(adc_valid), 0);
    check({pfx, "_adcl"},  32'(adc_l), 0);
    check({pfx, "_adcr"},  32'(adc_r), 0);
  endtask

  function automatic logic [DW-1:0] rnd16();
    return DW'($urandom) | 16'h8001;
  endfunction

  initial begin : main
    bit            m_run, m_drain, m_ready, m_under, en_s, val_s, acc, ld;
    int            k, n_loads, n_valid;
    logic [DW-1:0] m_bl, m_br;
    pair_t         p;

    m_run = 0; m_drain = 0; m_ready = 1; k = 0; n_loads = 0; n_valid = 0;
    m_bl = '0; m_br = '0;

    repeat (3) step();
    check_reset_outputs("rst");
    @(negedge clk_ir);
    rst_il = 1'b1;
    step();
    check_reset_outputs("idle");

    // Buffer a pair while idle; it goes out in the first frame.
    dac_l = 16'hA55A; dac_r = 16'h1234; dac_valid = 1'b1;
    step();
    check("idle_accept_ready", 32'(dac_ready), 0);
    m_ready = 0; m_bl = 16'hA55A; m_br = 16'h1234;
    dac_l = rnd16(); dac_r = rnd16();

    for (int g = 0; g <= LAST_G; g++) begin
      en_s  = (g < 3153) || (g >= 3600 && g < 3700) || (g >= 3900);
      val_s = (g < 1536) || (g >= 4200 && g < 4700);
      drvr_en   = en_s;
      dac_valid = val_s;

      acc = val_s && m_ready;
      ld  = 0;
      if (!m_run) begin
        if (en_s) begin
          m_run = 1; k = 0; ld = 1;
        end
      end else begin
        k++;
        if (k == 512) begin
          k = 0;
          if (m_drain && !en_s) m_run = 0;
          else                  ld = 1;
        end
      end
      if (m_run) m_drain = !en_s;
      m_under = ld && m_ready;
      if (ld) begin
        n_loads++;
        if (m_ready) sb_q.push_back('0);
        else begin
          sb_q.push_back({m_bl, m_br});
          m_ready = 1;
        end
      end
      if (acc) begin
        m_bl = dac_l; m_br = dac_r; m_ready = 0;
      end

      step();

      check($sformatf("bclk@%0d", g), 32'(bclk), m_run ? 32'((k / 4) % 2) : 0);
      check($sformatf("alrc@%0d", g), 32'(adc_lrc), (m_run && ((k / 8) % 64) >= 32) ? 1 : 0);
      check($sformatf("dlrc@%0d", g), 32'(dac_lrc), (m_run && ((k / 8) % 64) >= 32) ? 1 : 0);
      check($sformatf("ready@%0d", g), 32'(dac_ready), 32'(m_ready));
      check($sformatf("under@%0d", g), 32'(dac_under), 32'(m_under));
      if (g == 8)  check("dat_left_msb", 32'(dac_dat), 1);
      if (g == 16) check("dat_left_b14", 32'(dac_dat), 0);
      if (g < 8)   check($sformatf("dat_delay@%0d", g), 32'(dac_dat), 0);

      if (adc_valid) begin
        n_valid++;
        if (sb_q.size() == 0) check($sformatf("adc_extra@%0d", g), 1, 0);
        else begin
          p = sb_q.pop_front();
          check($sformatf("adc_l@%0d", g), 32'(adc_l), 32'(p.l));
          check($sformatf("adc_r@%0d", g), 32'(adc_r), 32'(p.r));
        end
      end
      if (acc) begin
        dac_l = rnd16(); dac_r = rnd16();
      end
    end
    check("sb_empty", 32'(sb_q.size()), 0);
    check("valid_count", 32'(n_valid), 32'(n_loads));

    // Mid-frame async reset with a sample held in the buffer.
    dac_valid = 1'b0;
    repeat (100) step();
    dac_valid = 1'b1;
    step();
    dac_valid = 1'b0;
    check("pre_rst_ready", 32'(dac_ready), 0);
    repeat (50) step();
    #3;
    rst_il = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk_ir);
    rst_il = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      step();
      check($sformatf("post_bclk@%0d", j), 32'(bclk), 32'((j / 4) % 2));
      check($sformatf("post_lrc@%0d", j), 32'(adc_lrc), 0);
      if (j == 0) check("post_under", 32'(dac_under), 1);
      if (j == 0) check("post_ready", 32'(dac_ready), 1);
      if (j == 8) check("post_dat", 32'(dac_dat), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
